// File: rtl/sbox_share_sched_if.sv
// Handshake bundle between the requesters and the shared S-box scheduler.
// Both the state job channel and the key word channel live here.
interface sbox_share_sched_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic         st_dir;
  logic [127:0] st_data;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         ky_req_valid;
  logic         ky_req_ready;
  logic [31:0]  ky_word;
  logic         ky_rsp_valid;
  logic         ky_rsp_ready;
  logic [31:0]  ky_rsp_word;
  logic         busy;

  modport master (
    output st_req_valid, st_dir, st_data, st_rsp_ready,
    output ky_req_valid, ky_word, ky_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  ky_req_ready, ky_rsp_valid, ky_rsp_word, busy
  );

  modport slave (
    input  st_req_valid, st_dir, st_data, st_rsp_ready,
    input  ky_req_valid, ky_word, ky_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output ky_req_ready, ky_rsp_valid, ky_rsp_word, busy
  );
endinterface

// File: rtl/sbox_share_sched.sv
// One 4-byte S-box word unit time-shared between a 4-beat state
// substitution and single-beat key SubWord requests.
module sbox_share_sched #(
  parameter int KEY_PREEMPT = 1
) (
  input logic               clk,
  input logic               rst_n,
  sbox_share_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } st_t;

  st_t          state;
  logic [1:0]   cnt;
  logic         stole_last;
  logic         sdir;
  logic [127:0] sbuf;
  logic [127:0] st_rsp_data;
  logic         st_rsp_valid;
  logic [31:0]  ky_rsp_word;
  logic         ky_rsp_valid;

  logic         kslot;
  logic         ky_acc;
  logic         st_acc;
  logic         beat;
  logic         unit_dir;
  logic [31:0]  unit_in;
  logic [31:0]  unit_out;
  logic [31:0]  st_word;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse, with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(
    input logic [7:0] x,
    input int         n
  );
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbyte(
    input logic       dir,
    input logic [7:0] b
  );
    logic [7:0] v;
    if (!dir) begin
      v = ginv(b);
      return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
    end
    v = rl(b, 1) ^ rl(b, 3) ^ rl(b, 6) ^ 8'h05;
    return ginv(v);
  endfunction

  assign kslot = (state != RUN) |
                 ((KEY_PREEMPT != 0) & ~stole_last);

  assign bus.ky_req_ready = kslot &
                            (~ky_rsp_valid | bus.ky_rsp_ready);
  assign bus.st_req_ready = (state == IDLE);

  assign ky_acc = bus.ky_req_valid & bus.ky_req_ready;
  assign st_acc = bus.st_req_valid & (state == IDLE);
  assign beat   = (state == RUN) & ~ky_acc;

  always_comb begin
    st_word = sbuf[127:96];
    unique case (cnt)
      2'd0: st_word = sbuf[127:96];
      2'd1: st_word = sbuf[95:64];
      2'd2: st_word = sbuf[63:32];
      2'd3: st_word = sbuf[31:0];
    endcase
  end

  assign unit_dir = ky_acc ? 1'b0 : sdir;
  assign unit_in  = ky_acc ? bus.ky_word : st_word;

  always_comb begin
    unit_out = 32'h0;
    for (int i = 0; i < 4; i++) begin
      unit_out[i*8 +: 8] = sbyte(unit_dir, unit_in[i*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      stole_last   <= 1'b0;
      sdir         <= 1'b0;
      sbuf         <= 128'h0;
      st_rsp_data  <= 128'h0;
      st_rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (st_acc) begin
            sbuf       <= bus.st_data;
            sdir       <= bus.st_dir;
            cnt        <= 2'd0;
            stole_last <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            unique case (cnt)
              2'd0: st_rsp_data[127:96] <= unit_out;
              2'd1: st_rsp_data[95:64]  <= unit_out;
              2'd2: st_rsp_data[63:32]  <= unit_out;
              2'd3: st_rsp_data[31:0]   <= unit_out;
            endcase
            cnt        <= cnt + 2'd1;
            stole_last <= 1'b0;
            if (cnt == 2'd3) begin
              state        <= DONE;
              st_rsp_valid <= 1'b1;
            end
          end else begin
            stole_last <= 1'b1;
          end
        end
        DONE: begin
          if (bus.st_rsp_ready) begin
            state        <= IDLE;
            st_rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ky_rsp_word  <= 32'h0;
      ky_rsp_valid <= 1'b0;
    end else if (ky_acc) begin
      ky_rsp_word  <= unit_out;
      ky_rsp_valid <= 1'b1;
    end else if (bus.ky_rsp_ready) begin
      ky_rsp_valid <= 1'b0;
    end
  end

  assign bus.st_rsp_valid = st_rsp_valid;
  assign bus.st_rsp_data  = st_rsp_data;
  assign bus.ky_rsp_valid = ky_rsp_valid;
  assign bus.ky_rsp_word  = ky_rsp_word;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench for sbox_share_sched: one preempting instance and one
// non-preempting instance driven through their own interfaces.
module tb_sbox_share_sched;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  sbox_share_sched_if if0 ();
  sbox_share_sched_if if1 ();

  sbox_share_sched #(.KEY_PREEMPT(1)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  sbox_share_sched #(.KEY_PREEMPT(0)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if0.st_req_valid = 0; if0.st_dir = 0; if0.st_data = '0;
    if0.st_rsp_ready = 0; if0.ky_req_valid = 0; if0.ky_word = '0;
    if0.ky_rsp_ready = 0;
    if1.st_req_valid = 0; if1.st_dir = 0; if1.st_data = '0;
    if1.st_rsp_ready = 0; if1.ky_req_valid = 0; if1.ky_word = '0;
    if1.ky_rsp_ready = 0;
  endtask

  // Presents a state job on if0 for one accept edge; returns #1 after it
  task automatic start0(input logic dir, input logic [127:0] d);
    if0.st_dir = dir;
    if0.st_data = d;
    if0.st_req_valid = 1;
    tick();
    if0.st_req_valid = 0;
  endtask

  // Waits for st_rsp_valid on if0; returns edges elapsed (bounded)
  task automatic wait_rsp0(output int lat);
    lat = 0;
    while (!if0.st_rsp_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume0();
    if0.st_rsp_ready = 1;
    tick();
    if0.st_rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    total++;
    if (if0.st_req_ready !== 1'b1)
      $display("FAIL rst_st_req_ready got %b exp 1", if0.st_req_ready);
    else passed++;
    total++;
    if (if0.busy !== 1'b0)
      $display("FAIL rst_busy got %b exp 0", if0.busy);
    else passed++;
    total++;
    if ({if0.st_rsp_valid, if0.ky_rsp_valid} !== 2'b00)
      $display("FAIL rst_valids got %b exp 00",
               {if0.st_rsp_valid, if0.ky_rsp_valid});
    else passed++;
    total++;
    if (if0.st_rsp_data !== 128'h0)
      $display("FAIL rst_st_data got %h exp 0", if0.st_rsp_data);
    else passed++;
    total++;
    if (if0.ky_rsp_word !== 32'h0)
      $display("FAIL rst_ky_word got %h exp 0", if0.ky_rsp_word);
    else passed++;
    total++;
    if (if0.ky_req_ready !== 1'b1)
      $display("FAIL rst_ky_req_ready got %b exp 1", if0.ky_req_ready);
    else passed++;
    #10 rst_n = 1;
    tick();
  endtask

  task automatic test_forward();
    int lat;
    int bz;
    start0(1'b0, {16{8'h00}});
    lat = 0;
    bz = 1;
    while (!if0.st_rsp_valid && lat < 12) begin
      if (if0.busy !== 1'b1) bz = 0;
      tick();
      lat++;
    end
    if (if0.busy !== 1'b1) bz = 0;
    total++;
    if (lat != 4) $display("FAIL fwd_latency got %0d exp 4", lat);
    else passed++;
    total++;
    if (bz != 1) $display("FAIL fwd_busy got 0 exp 1");
    else passed++;
    total++;
    if (if0.st_rsp_data !== {16{8'h63}})
      $display("FAIL fwd_data got %h exp %h", if0.st_rsp_data, {16{8'h63}});
    else passed++;
    consume0();
    total++;
    if (if0.st_rsp_valid !== 1'b0 || if0.busy !== 1'b0)
      $display("FAIL fwd_release got %b%b exp 00",
               if0.st_rsp_valid, if0.busy);
    else passed++;
  endtask

  task automatic test_inverse();
    int lat;
    start0(1'b1, {16{8'h63}});
    wait_rsp0(lat);
    total++;
    if (lat != 4 || if0.st_rsp_data !== 128'h0)
      $display("FAIL inv63 got lat %0d data %h exp lat 4 data 0",
               lat, if0.st_rsp_data);
    else passed++;
    consume0();
    start0(1'b1, {16{8'hED}});
    wait_rsp0(lat);
    total++;
    if (if0.st_rsp_data !== {16{8'h53}})
      $display("FAIL invED got %h exp %h", if0.st_rsp_data, {16{8'h53}});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if0.st_rsp_valid !== 1'b1 || if0.st_req_ready !== 1'b0 ||
          if0.st_rsp_data !== {16{8'h53}})
        $display("FAIL inv_hold got v%b r%b %h exp v1 r0 %h",
                 if0.st_rsp_valid, if0.st_req_ready,
                 if0.st_rsp_data, {16{8'h53}});
      else passed++;
    end
    consume0();
  endtask

  task automatic test_key_idle();
    if0.ky_rsp_ready = 1;
    if0.ky_word = 32'h00010253;
    if0.ky_req_valid = 1;
    total++;
    if (if0.ky_req_ready !== 1'b1)
      $display("FAIL key_ready got %b exp 1", if0.ky_req_ready);
    else passed++;
    tick();
    total++;
    if (if0.ky_rsp_valid !== 1'b1 || if0.ky_rsp_word !== 32'h637C77ED)
      $display("FAIL key_single got %b %h exp 1 637c77ed",
               if0.ky_rsp_valid, if0.ky_rsp_word);
    else passed++;
    if0.ky_word = 32'h00010203;
    total++;
    if (if0.ky_req_ready !== 1'b1)
      $display("FAIL key_b2b_ready got %b exp 1", if0.ky_req_ready);
    else passed++;
    tick();
    total++;
    if (if0.ky_rsp_word !== 32'h637C777B)
      $display("FAIL key_b2b_0 got %h exp 637c777b", if0.ky_rsp_word);
    else passed++;
    if0.ky_word = 32'h04050001;
    tick();
    total++;
    if (if0.ky_rsp_valid !== 1'b1 || if0.ky_rsp_word !== 32'hF26B637C)
      $display("FAIL key_b2b_1 got %b %h exp 1 f26b637c",
               if0.ky_rsp_valid, if0.ky_rsp_word);
    else passed++;
    if0.ky_req_valid = 0;
    tick();
    total++;
    if (if0.ky_rsp_valid !== 1'b0)
      $display("FAIL key_drain got %b exp 0", if0.ky_rsp_valid);
    else passed++;
    if0.ky_rsp_ready = 0;
  endtask

  task automatic test_preempt();
    logic [31:0] kw [4];
    logic [31:0] ks [4];
    kw[0] = 32'h00010253; ks[0] = 32'h637C77ED;
    kw[1] = 32'h00010203; ks[1] = 32'h637C777B;
    kw[2] = 32'h04050001; ks[2] = 32'hF26B637C;
    kw[3] = 32'h53020100; ks[3] = 32'hED777C63;
    start0(1'b0, {16{8'h01}});
    if0.ky_rsp_ready = 1;
    if0.ky_word = kw[0];
    if0.ky_req_valid = 1;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (if0.ky_req_ready !== logic'(c % 2 == 1))
        $display("FAIL pre_kready c%0d got %b exp %b",
                 c, if0.ky_req_ready, c % 2 == 1);
      else passed++;
      tick();
      if (c % 2 == 1) begin
        total++;
        if (if0.ky_rsp_valid !== 1'b1 ||
            if0.ky_rsp_word !== ks[(c-1)/2])
          $display("FAIL pre_key c%0d got %b %h exp 1 %h", c,
                   if0.ky_rsp_valid, if0.ky_rsp_word, ks[(c-1)/2]);
        else passed++;
        if (c < 7) if0.ky_word = kw[(c+1)/2];
        else if0.ky_req_valid = 0;
      end
      total++;
      if (if0.st_rsp_valid !== logic'(c == 8))
        $display("FAIL pre_st_valid c%0d got %b exp %b",
                 c, if0.st_rsp_valid, c == 8);
      else passed++;
    end
    total++;
    if (if0.st_rsp_data !== {16{8'h7C}})
      $display("FAIL pre_st_data got %h exp %h",
               if0.st_rsp_data, {16{8'h7C}});
    else passed++;
    consume0();
    if0.ky_rsp_ready = 0;
  endtask

  task automatic test_nopreempt();
    if1.st_dir = 0;
    if1.st_data = {16{8'h00}};
    if1.st_req_valid = 1;
    tick();
    if1.st_req_valid = 0;
    if1.ky_rsp_ready = 1;
    if1.ky_word = 32'h00010253;
    if1.ky_req_valid = 1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (if1.ky_req_ready !== 1'b0)
        $display("FAIL np_kready_run c%0d got %b exp 0",
                 c, if1.ky_req_ready);
      else passed++;
      tick();
    end
    total++;
    if (if1.ky_req_ready !== 1'b1 || if1.st_rsp_valid !== 1'b1)
      $display("FAIL np_done got kr%b sv%b exp 11",
               if1.ky_req_ready, if1.st_rsp_valid);
    else passed++;
    tick();
    if1.ky_req_valid = 0;
    total++;
    if (if1.ky_rsp_valid !== 1'b1 || if1.ky_rsp_word !== 32'h637C77ED)
      $display("FAIL np_key got %b %h exp 1 637c77ed",
               if1.ky_rsp_valid, if1.ky_rsp_word);
    else passed++;
    total++;
    if (if1.st_rsp_data !== {16{8'h63}})
      $display("FAIL np_st_data got %h exp %h",
               if1.st_rsp_data, {16{8'h63}});
    else passed++;
    if1.st_rsp_ready = 1;
    tick();
    if1.st_rsp_ready = 0;
    if1.ky_rsp_ready = 0;
  endtask

  task automatic test_reset_midjob();
    int lat;
    start0(1'b0, {16{8'h00}});
    tick();
    tick();
    rst_n = 0;
    #1;
    total++;
    if (if0.busy !== 1'b0 || if0.st_rsp_valid !== 1'b0 ||
        if0.st_req_ready !== 1'b1)
      $display("FAIL mid_rst_ctl got b%b v%b r%b exp b0 v0 r1",
               if0.busy, if0.st_rsp_valid, if0.st_req_ready);
    else passed++;
    total++;
    if (if0.st_rsp_data !== 128'h0)
      $display("FAIL mid_rst_data got %h exp 0", if0.st_rsp_data);
    else passed++;
    #5 rst_n = 1;
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (if0.st_rsp_valid !== 1'b0 || if0.busy !== 1'b0)
      $display("FAIL mid_rst_abandon got v%b b%b exp v0 b0",
               if0.st_rsp_valid, if0.busy);
    else passed++;
    start0(1'b0, {16{8'h01}});
    wait_rsp0(lat);
    total++;
    if (lat != 4 || if0.st_rsp_data !== {16{8'h7C}})
      $display("FAIL mid_rst_rerun got lat %0d %h exp lat 4 %h",
               lat, if0.st_rsp_data, {16{8'h7C}});
    else passed++;
    consume0();
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_forward();
    test_inverse();
    test_key_idle();
    test_preempt();
    test_nopreempt();
    test_reset_midjob();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Time-shares one 4-byte S-box word unit (inputs dir and 32-bit word, output 32-bit substituted word; combinational) between two requesters.
- Requester 1 is the cipher datapath. It needs a 128-bit SubBytes/InvSubBytes, done as 4 word beats.
- Requester 2 is key expansion. It needs a 32-bit forward SubWord, done in 1 beat.
- The block replaces four parallel word units in the area-reduced AES core, and sits between the round controller/key scheduler and the S-box logic.

Parameters:
- KEY_PREEMPT, default 1: 1 lets key requests steal unit cycles between state beats; 0 makes key requests wait until no state job is running.

Ports:
- clk  in  1  clock; all flops rise-edge triggered.
- rst_n  in  1  asynchronous active-low reset.
- st_req_valid  in  1  state job request.
- st_req_ready  out  1  state job accepted when valid & ready at an edge.
- st_dir  in  1  0 = forward S-box, 1 = inverse; sampled at accept.
- st_data  in  128  state to substitute; sampled at accept.
- st_rsp_valid  out  1  substituted state available.
- st_rsp_ready  in  1  consumer takes the state response.
- st_rsp_data  out  128  substituted state.
- ky_req_valid  in  1  key word request.
- ky_req_ready  out  1  key word accepted when valid & ready.
- ky_word  in  32  key word; always forward S-box.
- ky_rsp_valid  out  1  key response available.
- ky_rsp_ready  in  1  consumer takes the key response.
- ky_rsp_word  out  32  substituted key word.
- busy  out  1  state engine not IDLE.

Behaviour:
- Reset (async, rst_n=0), all cleared: FSM=IDLE, beat counter=0, stole_last=0, st_rsp_valid=0, ky_rsp_valid=0, st_rsp_data=0, ky_rsp_word=0, internal buffers=0. This gives st_req_ready=1 and busy=0. A reset mid-job abandons the job; no response is produced afterwards.
- State FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE
  - st_req_ready=1.
  - On accept: latch st_data and st_dir, cnt=0, stole_last=0, go to RUN.
- RUN
  - st_req_ready=0.
  - Each cycle is either a state beat or a key steal.
  - State beat: unit input = buffered word[cnt]. Word 0 = bits 127:96, word 3 = bits 31:0. Result is written to the matching 32-bit slice of st_rsp_data at the edge. Then cnt++ and stole_last=0.
  - On the cnt=3 beat edge, go to DONE.
- DONE
  - st_rsp_valid=1; st_rsp_data is stable.
  - On st_rsp_ready, go to IDLE; st_rsp_valid=0 next cycle.
  - A new request is not accepted in the same cycle as the response handshake.
- Key grant:
  - kslot = (FSM != RUN) | (KEY_PREEMPT & ~stole_last).
  - ky_req_ready = kslot & (~ky_rsp_valid | ky_rsp_ready).
- Key accept cycle:
  - Unit input = {dir=0, ky_word}; ky_rsp_word is registered at the edge and ky_rsp_valid=1 next cycle (1-cycle latency).
  - If the FSM is in RUN, this cycle is a steal: cnt holds and stole_last=1.
- ky_rsp_valid holds until ky_rsp_ready. If a response handshake and a new accept happen in the same cycle, ky_rsp_valid stays 1 with the new word.
- No two consecutive steals, so a state job finishes within 8 cycles of accept.
- State latency: st_rsp_valid rises 4 + (number of steals) cycles after the accept edge; range 4..8.
- With KEY_PREEMPT=0, key requests stall during RUN. They are serviced in IDLE and DONE.
- Unit mux priority: a key accept beats a state beat in the same cycle. There is never a combinational path from valid to ready within one requester except via kslot.
- Outputs are registered except the ready signals, which are combinational from FSM state, stole_last, ky_rsp_valid and ky_rsp_ready.

Test Plan:
- Forward state job: st_data=128'h0 (all zero), dir=0, no key traffic -> st_rsp_data=128'h6363..63, st_rsp_valid rises exactly 4 cycles after the accept edge, busy=1 throughout.
- Inverse state job: st_data=all 8'h63, dir=1 -> all 8'h00. Then st_data=all 8'hED, dir=1 -> all 8'h53. Hold st_rsp_ready=0 for 3 cycles -> data is stable and st_req_ready=0.
- Key only, idle engine: ky_word=32'h00010253 -> ky_rsp_word=32'h637C77ED one cycle after accept. Back-to-back words with ky_rsp_ready=1 -> one accept per cycle.
- Preemption, KEY_PREEMPT=1: continuous ky_req_valid and ky_rsp_ready=1 during a state job -> steal/beat alternate. State response arrives 8 cycles after accept and is still correct; 4 key responses are correct.
- KEY_PREEMPT=0: key request raised during RUN -> ky_req_ready=0 until DONE. The key is accepted in DONE, and the state result is unaffected.
- Reset mid-job: assert rst_n=0 at beat 2 -> all outputs 0 immediately. After release, a new job with all 8'h01 returns all 8'h7C.
